// File: rtl/axis_pixels_shift.sv
// axis_pixels_shift: holds one wide input beat of IM_SHIFT_REGS words and
// streams UNITS-word windows out of it at offsets j = 0..shift_eff, one
// window per output handshake, then releases the beat.
// Optional feature macro: PIXELS_SHIFT_INDEX_EN -- when defined, m_index
// reports the current window offset j; otherwise m_index is tied to zero.
module axis_pixels_shift #(
  parameter int UNITS              = 8,
  parameter int IM_SHIFT_REGS      = 10,  // must be >= UNITS
  parameter int WORD_WIDTH         = 8,
  parameter int BITS_IM_SHIFT      = 2,
  parameter int TUSER_WIDTH_PIXELS = 3
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [IM_SHIFT_REGS*WORD_WIDTH-1:0] s_data,
  input  logic [BITS_IM_SHIFT-1:0]            s_shift,
  input  logic                                s_ones,
  input  logic [TUSER_WIDTH_PIXELS-1:0]       s_user,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [UNITS*WORD_WIDTH-1:0]         m_data,
  output logic                                m_ones,
  output logic [TUSER_WIDTH_PIXELS-1:0]       m_user,
  output logic                                m_last,
  output logic [BITS_IM_SHIFT-1:0]            m_index
);

  localparam int IN_W      = IM_SHIFT_REGS * WORD_WIDTH;
  localparam int OUT_W     = UNITS * WORD_WIDTH;
  localparam int MAX_SHIFT = IM_SHIFT_REGS - UNITS;

  localparam logic [BITS_IM_SHIFT-1:0] MAX_SHIFT_V = BITS_IM_SHIFT'(MAX_SHIFT);
  localparam logic [BITS_IM_SHIFT-1:0] J_ZERO      = {BITS_IM_SHIFT{1'b0}};
  localparam logic [BITS_IM_SHIFT-1:0] J_ONE       = {{(BITS_IM_SHIFT-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  // Effective number of extra windows: ones/config beats emit a single
  // window, and oversize shifts saturate so the window never runs past
  // the end of the held beat.
  function automatic logic [BITS_IM_SHIFT-1:0] shift_eff(
    input logic [BITS_IM_SHIFT-1:0] shift,
    input logic                     ones
  );
    logic [BITS_IM_SHIFT-1:0] r;
    if (ones) begin
      r = J_ZERO;
    end else if (shift > MAX_SHIFT_V) begin
      r = MAX_SHIFT_V;
    end else begin
      r = shift;
    end
    return r;
  endfunction

  // UNITS-word window starting at word 'off' of the held beat.
  function automatic logic [OUT_W-1:0] window(
    input logic [IN_W-1:0]          d,
    input logic [BITS_IM_SHIFT-1:0] off
  );
    logic [IN_W-1:0] t;
    t = d >> (int'(off) * WORD_WIDTH);
    return t[OUT_W-1:0];
  endfunction

  // Held beat and sequencing state.
  state_t                          state;
  state_t                          state_n;
  logic [IN_W-1:0]                 hold_data;
  logic [IN_W-1:0]                 hold_data_n;
  logic [BITS_IM_SHIFT-1:0]        hold_shift;
  logic [BITS_IM_SHIFT-1:0]        hold_shift_n;
  logic                            hold_ones;
  logic                            hold_ones_n;
  logic [TUSER_WIDTH_PIXELS-1:0]   hold_user;
  logic [TUSER_WIDTH_PIXELS-1:0]   hold_user_n;
  logic [BITS_IM_SHIFT-1:0]        j;
  logic [BITS_IM_SHIFT-1:0]        j_n;
  logic                            load;

  // Next-output values, derived from next-state so outputs are registered.
  logic [OUT_W-1:0]                m_data_n;
  logic                            m_last_n;
  logic                            m_valid_n;

  // The user and ones sideband come straight from the held registers.
  assign m_user = hold_user;
  assign m_ones = hold_ones;

  // Input ready: always open when empty; while emitting, only on the final
  // window's handshake so the next beat can be taken without a bubble.
  always_comb begin
    if (state == S_EMIT) begin
      s_ready = m_ready & m_last;
    end else begin
      s_ready = 1'b1;
    end
  end

  // Next-state logic: load a new beat, advance j, or release the buffer.
  always_comb begin
    state_n      = state;
    j_n          = j;
    hold_data_n  = hold_data;
    hold_shift_n = hold_shift;
    hold_ones_n  = hold_ones;
    hold_user_n  = hold_user;
    load         = 1'b0;

    case (state)
      S_LOAD: begin
        if (s_valid) begin
          load    = 1'b1;
          state_n = S_EMIT;
        end else begin
          state_n = S_LOAD;
        end
      end
      S_EMIT: begin
        if (m_ready) begin
          if (!m_last) begin
            j_n = j + J_ONE;
          end else if (s_valid) begin
            load    = 1'b1;
            state_n = S_EMIT;
          end else begin
            state_n = S_LOAD;
          end
        end else begin
          state_n = S_EMIT;
        end
      end
      default: begin
        state_n = S_LOAD;
      end
    endcase

    if (load) begin
      hold_data_n  = s_data;
      hold_shift_n = s_shift;
      hold_ones_n  = s_ones;
      hold_user_n  = s_user;
      j_n          = J_ZERO;
    end else begin
      hold_data_n  = hold_data_n;
    end
  end

  // Next registered output values, computed from the next held state.
  always_comb begin
    m_data_n  = window(hold_data_n, j_n);
    m_last_n  = (j_n == shift_eff(hold_shift_n, hold_ones_n));
    m_valid_n = (state_n == S_EMIT);
  end

  // State, held beat and registered outputs; reset empties the buffer and
  // drops any partially emitted beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= S_LOAD;
      hold_data  <= {IN_W{1'b0}};
      hold_shift <= J_ZERO;
      hold_ones  <= 1'b0;
      hold_user  <= {TUSER_WIDTH_PIXELS{1'b0}};
      j          <= J_ZERO;
      m_data     <= {OUT_W{1'b0}};
      m_last     <= 1'b1;
      m_valid    <= 1'b0;
    end else begin
      state      <= state_n;
      hold_data  <= hold_data_n;
      hold_shift <= hold_shift_n;
      hold_ones  <= hold_ones_n;
      hold_user  <= hold_user_n;
      j          <= j_n;
      m_data     <= m_data_n;
      m_last     <= m_last_n;
      m_valid    <= m_valid_n;
    end
  end

`ifdef PIXELS_SHIFT_INDEX_EN
  // Window offset exported for debug and downstream tap selection.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_index <= J_ZERO;
    end else begin
      m_index <= j_n;
    end
  end
`else
  assign m_index = J_ZERO;
`endif

endmodule

// File: tb/tb_axis_pixels_shift.sv
// Scoreboard bench for axis_pixels_shift: stimulus pushes expected windows,
// a negedge monitor pops and compares on every output handshake.
module tb_axis_pixels_shift;

  localparam int UNITS = 8;
  localparam int IM    = 10;
  localparam int WW    = 8;
  localparam int BS    = 2;
  localparam int TU    = 3;
`ifdef PIXELS_SHIFT_INDEX_EN
  localparam bit IDX_EN = 1'b1;
`else
  localparam bit IDX_EN = 1'b0;
`endif

  logic              aclk;
  logic              areset;
  logic              s_valid;
  logic              s_ready;
  logic [IM*WW-1:0]  s_data;
  logic [BS-1:0]     s_shift;
  logic              s_ones;
  logic [TU-1:0]     s_user;
  logic              m_valid;
  logic              m_ready;
  logic [UNITS*WW-1:0] m_data;
  logic              m_ones;
  logic [TU-1:0]     m_user;
  logic              m_last;
  logic [BS-1:0]     m_index;

  axis_pixels_shift #(
    .UNITS(UNITS), .IM_SHIFT_REGS(IM), .WORD_WIDTH(WW),
    .BITS_IM_SHIFT(BS), .TUSER_WIDTH_PIXELS(TU)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_shift(s_shift), .s_ones(s_ones), .s_user(s_user),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_ones(m_ones), .m_user(m_user), .m_last(m_last), .m_index(m_index)
  );

  typedef struct {
    logic [63:0] data;
    logic [2:0]  user;
    logic        ones;
    logic        last;
    logic [1:0]  idx;
  } exp_t;

  exp_t sb[$];
  int   fire_q[$];
  int   acc_q[$];
  bit   rdy_hist[int];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [79:0] mk(input logic [7:0] base);
    logic [79:0] r;
    for (int i = 0; i < 10; i++) r[i*8 +: 8] = base + 8'(i);
    return r;
  endfunction

  function automatic void push_win(input logic [63:0] d, input logic [2:0] u,
                                   input logic o, input logic l, input int jj);
    exp_t e;
    e.data = d; e.user = u; e.ones = o; e.last = l;
    e.idx  = IDX_EN ? 2'(jj) : 2'd0;
    sb.push_back(e);
  endfunction

  function automatic void push_beat(input logic [79:0] d, input int eff,
                                    input logic o, input logic [2:0] u);
    logic [79:0] t;
    for (int jj = 0; jj <= eff; jj++) begin
      t = d >> (8 * jj);
      push_win(t[63:0], u, o, (jj == eff), jj);
    end
  endfunction

  // Monitor: log ready history and check every output handshake.
  initial forever begin
    exp_t e;
    @(negedge aclk);
    rdy_hist[cyc] = s_ready;
    if (s_valid && s_ready) acc_q.push_back(cyc);
    if (m_valid && m_ready) begin
      fire_q.push_back(cyc);
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_beat: got data %0h expected no beat", m_data);
      end else begin
        e = sb.pop_front();
        chk("m_data",  m_data,  e.data);
        chk("m_user",  m_user,  e.user);
        chk("m_ones",  m_ones,  e.ones);
        chk("m_last",  m_last,  e.last);
        chk("m_index", m_index, e.idx);
      end
    end
  end

  task automatic send_beat(input logic [79:0] d, input logic [1:0] sh,
                           input logic o, input logic [2:0] u);
    bit got;
    s_data = d; s_shift = sh; s_ones = o; s_user = u; s_valid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge aclk);
      if (s_ready) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL send_timeout: got s_ready 0 expected 1");
    end
    @(posedge aclk); #1;
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge aclk);
    chk({name, "_drain"}, 80'(sb.size()), 80'd0);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk({name, "_idle_valid"}, m_valid, 1'b0);
    @(posedge aclk); #1;
  endtask

  logic [79:0] d1;
  int a0;

  initial begin
    areset = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    s_data = '0; s_shift = 2'd0; s_ones = 1'b0; s_user = 3'd0;
    d1 = 80'h1312_1110_0F0E_0D0C_0B0A;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_m_data",  m_data,  64'd0);
    chk("rst_m_user",  m_user,  3'd0);
    chk("rst_m_ones",  m_ones,  1'b0);
    chk("rst_m_index", m_index, 2'd0);
    chk("rst_m_last",  m_last,  1'b1);
    @(posedge aclk); #1;
    areset = 1'b0;

    // Single beat, shift 2: three windows of words 10..19
    m_ready = 1'b1;
    push_win(64'h1110_0F0E_0D0C_0B0A, 3'd1, 1'b0, 1'b0, 0);
    push_win(64'h1211_100F_0E0D_0C0B, 3'd1, 1'b0, 1'b0, 1);
    push_win(64'h1312_1110_0F0E_0D0C, 3'd1, 1'b0, 1'b1, 2);
    send_beat(d1, 2'd2, 1'b0, 3'd1);
    s_valid = 1'b0;
    wait_drain("single");

    // Ones beat ignores shift and emits one window
    push_win(64'h0000_0000_0000_0001, 3'd6, 1'b1, 1'b1, 0);
    send_beat(80'h1, 2'd2, 1'b1, 3'd6);
    s_valid = 1'b0;
    wait_drain("ones");

    // Back-to-back shift-1 beats
    fire_q.delete(); acc_q.delete();
    for (int k = 0; k < 4; k++) push_beat(mk(8'(8'h20 + 8'(k * 16))), 1, 1'b0, 3'(k));
    for (int k = 0; k < 4; k++) send_beat(mk(8'(8'h20 + 8'(k * 16))), 2'd1, 1'b0, 3'(k));
    s_valid = 1'b0;
    wait_drain("b2b");
    chk("b2b_accepts", 80'(acc_q.size()), 80'd4);
    chk("b2b_fires", 80'(fire_q.size()), 80'd8);
    if (acc_q.size() > 0 && fire_q.size() == 8) begin
      a0 = acc_q[0];
      for (int k = 0; k < 8; k++) begin
        chk("b2b_fire_cycle", 80'(fire_q[k]), 80'(a0 + 1 + k));
        chk("b2b_s_ready", rdy_hist[a0 + k], 1'(k % 2 == 0));
      end
    end

    // Backpressure at j=1 for five cycles
    m_ready = 1'b0;
    push_beat(mk(8'h40), 2, 1'b0, 3'd2);
    send_beat(mk(8'h40), 2'd2, 1'b0, 3'd2);
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge aclk); #1;
    m_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge aclk);
      chk("bp_m_data",  m_data,  64'h4847_4645_4443_4241);
      chk("bp_m_last",  m_last,  1'b0);
      chk("bp_m_index", m_index, IDX_EN ? 2'd1 : 2'd0);
      chk("bp_m_valid", m_valid, 1'b1);
      chk("bp_s_ready", s_ready, 1'b0);
      @(posedge aclk); #1;
    end
    m_ready = 1'b1;
    wait_drain("bp");

    // Reset while j=1 of a shift-2 beat
    push_win(64'h6766_6564_6362_6160, 3'd3, 1'b0, 1'b0, 0);
    send_beat(mk(8'h60), 2'd2, 1'b0, 3'd3);
    s_valid = 1'b0;
    @(posedge aclk); #1;
    m_ready = 1'b0;
    areset  = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("mid_rst_m_valid", m_valid, 1'b0);
    chk("mid_rst_s_ready", s_ready, 1'b1);
    chk("mid_rst_m_data",  m_data,  64'd0);
    chk("mid_rst_m_last",  m_last,  1'b1);
    chk("mid_rst_m_index", m_index, 2'd0);
    chk("mid_rst_sb", 80'(sb.size()), 80'd0);
    @(posedge aclk); #1;
    areset  = 1'b0;
    m_ready = 1'b1;
    push_beat(mk(8'h80), 1, 1'b0, 3'd4);
    send_beat(mk(8'h80), 2'd1, 1'b0, 3'd4);
    s_valid = 1'b0;
    wait_drain("post_rst");

    // Saturation: shift 3 clamps to 2
    push_win(64'h1110_0F0E_0D0C_0B0A, 3'd7, 1'b0, 1'b0, 0);
    push_win(64'h1211_100F_0E0D_0C0B, 3'd7, 1'b0, 1'b0, 1);
    push_win(64'h1312_1110_0F0E_0D0C, 3'd7, 1'b0, 1'b1, 2);
    send_beat(d1, 2'd3, 1'b0, 3'd7);
    s_valid = 1'b0;
    wait_drain("sat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

endmodule
